sha256_round_ctrl: RTL and testbench

SHA256_ROUND_CTRL -- requirements
Module: sha256_round_ctrl

---
 rtl/sha256_pkg.sv | 59 +++++
 rtl/sha256_round_step.sv | 21 ++
 rtl/sha256_round_ctrl.sv | 118 +++++++++++
 tb/tb_sha256_round_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state type, working-variable struct and bit helpers
// used by the round controller and its combinational round step.
package sha256_pkg;

  typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_ROUND, ST_FINAL, ST_DONE} state_e;

  // Field a maps to H0 / digest[255:224] when the struct is used as the hash state.
  typedef struct packed {
    logic [31:0] a, b, c, d, e, f, g, h;
  } work_t;

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam work_t IV = work_t'({
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  });

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] shr(input logic [31:0] x, input int unsigned n);
    return x >> n;
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ shr(x, 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ shr(x, 10);
  endfunction

  function automatic work_t add_work(input work_t x, input work_t y);
    work_t r;
    r.a = x.a + y.a; r.b = x.b + y.b; r.c = x.c + y.c; r.d = x.d + y.d;
    r.e = x.e + y.e; r.f = x.f + y.f; r.g = x.g + y.g; r.h = x.h + y.h;
    return r;
  endfunction

endpackage

// File: rtl/sha256_round_step.sv
// One combinational SHA-256 compression round: a..h plus K[i] and W[i] in, next a..h out.
module sha256_round_step
  import sha256_pkg::*;
(
  input  work_t       work_i,
  input  logic [31:0] k_i,
  input  logic [31:0] w_i,
  output work_t       work_o
);

  logic [31:0] ch, maj, t1, t2;

  assign ch  = (work_i.e & work_i.f) ^ (~work_i.e & work_i.g);
  assign maj = (work_i.a & work_i.b) ^ (work_i.a & work_i.c) ^ (work_i.b & work_i.c);
  assign t1  = work_i.h + bsig1(work_i.e) + ch + k_i + w_i;
  assign t2  = bsig0(work_i.a) + maj;

  assign work_o = '{a: t1 + t2, b: work_i.a, c: work_i.b, d: work_i.c,
                    e: work_i.d + t1, f: work_i.e, g: work_i.f, h: work_i.g};

endmodule

// File: rtl/sha256_round_ctrl.sv
// SHA-256 block controller: loads 16 words, runs ROUNDS rounds with an on-the-fly
// message schedule, folds the result into H and holds the digest until taken.
module sha256_round_ctrl
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         init,
  input  logic         w_valid,
  output logic         w_ready,
  input  logic [31:0]  w_data,
  output logic         busy,
  output logic         digest_valid,
  input  logic         digest_ready,
  output logic [255:0] digest
);

  localparam logic [5:0] LAST_ROUND = 6'(ROUNDS - 1);

  state_e      state_q;
  work_t       h_q, wk_q, wk_d;
  logic [3:0]  cnt_q;
  logic [5:0]  round_q;
  logic        w_ready_q, busy_q, dv_q;
  logic [31:0] w_q [16];
  logic [31:0] w_new, w_cur;
  logic        accept;

  assign accept = w_valid && w_ready_q;

  // Circular schedule: slot i[3:0] holds W[i-16] until overwritten with W[i].
  assign w_new = ssig1(w_q[round_q[3:0] - 4'd2]) + w_q[round_q[3:0] - 4'd7]
               + ssig0(w_q[round_q[3:0] - 4'd15]) + w_q[round_q[3:0]];
  assign w_cur = (round_q < 6'd16) ? w_q[round_q[3:0]] : w_new;

  sha256_round_step u_step (
    .work_i (wk_q),
    .k_i    (K[round_q]),
    .w_i    (w_cur),
    .work_o (wk_d)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      w_q[cnt_q] <= w_data;
    end else if (state_q == ST_ROUND && round_q >= 6'd16) begin
      w_q[round_q[3:0]] <= w_new;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      w_ready_q <= 1'b0;
      busy_q    <= 1'b0;
      dv_q      <= 1'b0;
      h_q       <= IV;
      wk_q      <= '0;
      cnt_q     <= '0;
      round_q   <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (init) h_q <= IV;
            wk_q      <= init ? IV : h_q;
            cnt_q     <= '0;
            state_q   <= ST_LOAD;
            w_ready_q <= 1'b1;
            busy_q    <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (accept) begin
            cnt_q <= cnt_q + 4'd1;
            if (cnt_q == 4'd15) begin
              state_q   <= ST_ROUND;
              round_q   <= '0;
              w_ready_q <= 1'b0;
            end
          end
        end
        ST_ROUND: begin
          wk_q    <= wk_d;
          round_q <= round_q + 6'd1;
          if (round_q == LAST_ROUND) state_q <= ST_FINAL;
        end
        ST_FINAL: begin
          h_q     <= add_work(h_q, wk_q);
          dv_q    <= 1'b1;
          state_q <= ST_DONE;
        end
        ST_DONE: begin
          if (digest_ready) begin
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          w_ready_q <= 1'b0;
          busy_q    <= 1'b0;
          dv_q      <= 1'b0;
        end
      endcase
    end
  end

  assign w_ready      = w_ready_q;
  assign busy         = busy_q;
  assign digest_valid = dv_q;
  assign digest       = h_q;

endmodule

// File: tb/tb_sha256_round_ctrl.sv
// Bench for sha256_round_ctrl: a plain-arithmetic SHA-256 compress model checked
// every cycle against the DUT, pinned by known digests of standard test blocks.
module tb_sha256_round_ctrl;

  localparam int ROUNDS = 64;

  localparam logic [31:0] KT [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };
  localparam logic [255:0] IV_T = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;

  localparam logic [511:0] BLK_ABC   = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] BLK_EMPTY = {32'h80000000, 480'h0};
  localparam logic [511:0] BLK_TWO1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                        32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                        32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                        32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam logic [511:0] BLK_TWO2  = {480'h0, 32'h000001c0};
  localparam logic [255:0] DIG_ABC   = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] DIG_EMPTY = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] DIG_TWO   = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0, init = 1'b0, w_valid = 1'b0, digest_ready = 1'b0;
  logic [31:0]  w_data = '0;
  logic         w_ready, busy, digest_valid;
  logic [255:0] digest;

  int           checks = 0;
  int           errors = 0;
  logic [255:0] exp_hold = IV_T;
  logic [255:0] exp_digest = IV_T;
  bit           acc_seen;

  sha256_round_ctrl #(.ROUNDS(ROUNDS)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .init(init),
    .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
    .busy(busy), .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest(digest)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Reference compression written straight from the SHA-256 definition.
  function automatic logic [255:0] compress(input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] v [8];
    logic [31:0] t1, t2;
    logic [255:0] r;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = blk[511 - 32*t -: 32];
      else w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    for (int j = 0; j < 8; j++) v[j] = hin[255 - 32*j -: 32];
    for (int t = 0; t < 64; t++) begin
      t1 = v[7] + (rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25))
         + ((v[4] & v[5]) ^ (~v[4] & v[6])) + KT[t] + w[t];
      t2 = (rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22))
         + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
      for (int j = 7; j > 0; j--) v[j] = v[j-1];
      v[4] = v[4] + t1;
      v[0] = t1 + t2;
    end
    for (int j = 0; j < 8; j++) r[255 - 32*j -: 32] = hin[255 - 32*j -: 32] + v[j];
    return r;
  endfunction

  task automatic compare_cycle();
    logic [255:0] want;
    acc_seen = w_valid && w_ready;
    checks++;
    if (!rst_n) begin
      exp_hold = IV_T;
      if (busy || digest_valid || w_ready) begin
        errors++;
        $display("FAIL reset_flags busy=%0b valid=%0b w_ready=%0b required 0 0 0", busy, digest_valid, w_ready);
      end
    end else if ((w_ready && !busy) || (digest_valid && !busy) || (w_ready && digest_valid)) begin
      errors++;
      $display("FAIL flags busy=%0b valid=%0b w_ready=%0b inconsistent", busy, digest_valid, w_ready);
    end
    want = digest_valid ? exp_digest : exp_hold;
    checks++;
    if (digest !== want) begin
      errors++;
      $display("FAIL digest got %064h required %064h", digest, want);
    end
    if (rst_n && digest_valid && digest_ready) exp_hold = exp_digest;
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [255:0] got, input logic [255:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, want);
    end
  endtask

  task automatic feed_words(input logic [511:0] blk, input bit gaps, input bit spam, input string name);
    int j = 0;
    int budget = 0;
    while (j < 16 && budget < 200) begin
      w_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      w_data  = blk[511 - 32*j -: 32];
      start   = spam;
      tick();
      if (acc_seen) j++;
      budget++;
    end
    w_valid = 1'b0;
    w_data  = 32'hdeadbeef;
    checks++;
    if (j != 16) begin
      errors++;
      $display("FAIL %s_load_timeout got %0d words required 16", name, j);
    end
  endtask

  task automatic run_block(input logic [511:0] blk, input bit init_b, input bit gaps,
                           input int hold, input bit spam, input logic [255:0] lit, input string name);
    int n = 0;
    exp_digest = compress(init_b ? IV_T : exp_hold, blk);
    w_valid = 1'b1;
    w_data  = 32'hbadc0de0;
    tick();
    start = 1'b1;
    init  = init_b;
    tick();
    start = 1'b0;
    init  = 1'b0;
    if (init_b) exp_hold = IV_T;
    feed_words(blk, gaps, spam, name);
    while (!digest_valid && n < 200) begin
      start = spam;
      tick();
      n++;
    end
    checks++;
    if (n != ROUNDS + 1) begin
      errors++;
      $display("FAIL %s_latency got %0d edges required %0d", name, n, ROUNDS + 1);
    end
    repeat (hold) begin
      start = spam;
      tick();
    end
    check({name, "_valid_held"}, {255'h0, digest_valid}, 256'h1);
    check({name, "_digest"}, digest, lit);
    start = 1'b0;
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    check({name, "_after_handshake"}, {254'h0, busy, digest_valid}, 256'h0);
    $display("block %s init=%0b gaps=%0b hold=%0d digest=%064h", name, init_b, gaps, hold, digest);
  endtask

  initial begin
    check("model_abc", compress(IV_T, BLK_ABC), DIG_ABC);
    check("model_empty", compress(IV_T, BLK_EMPTY), DIG_EMPTY);
    check("model_two", compress(compress(IV_T, BLK_TWO1), BLK_TWO2), DIG_TWO);

    tick();
    tick();
    check("reset_digest", digest, IV_T);
    rst_n = 1'b1;
    tick();

    run_block(BLK_ABC,   1'b1, 1'b0, 0,  1'b0, DIG_ABC,   "abc");
    run_block(BLK_EMPTY, 1'b1, 1'b0, 3,  1'b0, DIG_EMPTY, "empty");
    run_block(BLK_TWO1,  1'b1, 1'b0, 0,  1'b0, compress(IV_T, BLK_TWO1), "two_b1");
    run_block(BLK_TWO2,  1'b0, 1'b0, 0,  1'b0, DIG_TWO,   "two_b2");
    run_block(BLK_ABC,   1'b1, 1'b1, 20, 1'b1, DIG_ABC,   "abc_gaps");
    run_block(BLK_EMPTY, 1'b1, 1'b0, 0,  1'b0, DIG_EMPTY, "empty_pre_reset");

    // Abort an abc block at round 30 with an asynchronous reset.
    exp_digest = compress(IV_T, BLK_ABC);
    start = 1'b1;
    init  = 1'b1;
    tick();
    start = 1'b0;
    init  = 1'b0;
    exp_hold = IV_T;
    feed_words(BLK_ABC, 1'b0, 1'b0, "abort");
    repeat (30) tick();
    rst_n = 1'b0;
    #1;
    check("midround_reset_busy", {255'h0, busy}, 256'h0);
    check("midround_reset_digest", digest, IV_T);
    $display("midround reset busy=%0b digest=%064h", busy, digest);
    tick();
    rst_n = 1'b1;
    tick();

    run_block(BLK_ABC, 1'b0, 1'b0, 2, 1'b0, DIG_ABC, "abc_after_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
